// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight GPR writers and raises a decode stall
// when an instruction reads a register that still has a write pending, or
// when a destination's pending-write counter is saturated.
// Optional feature: define SB_WB_BYPASS_EN so that a source whose last pending
// write retires in the same cycle does not stall.
module reg_scoreboard #(
  parameter int NREGS = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v,
  input  logic             ro_needed,
  input  logic             rm_needed,
  input  logic [7:0]       modrm,
  input  logic             issue,
  input  logic             wr_en,
  input  logic             wr_rmsel,
  input  logic             wb_v,
  input  logic [IDX_W-1:0] wb_reg,
  input  logic             flush,
  output logic             reg_dep,
  output logic [NREGS-1:0] busy,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];

  logic [IDX_W-1:0] ro_idx;
  logic [IDX_W-1:0] rm_idx;
  logic [IDX_W-1:0] dest_idx;
  logic             rm_is_reg;
  logic             dest_valid;
  logic             ro_byp;
  logic             rm_byp;
  logic             ro_busy;
  logic             rm_busy;
  logic             dest_full;
  logic             inc;
  logic             dec;
  logic             underflow;

  // The ModR/M fields are 3 bits; fit them to the register index width.
  generate
    if (IDX_W == 3) begin : g_idx_eq
      assign ro_idx = modrm[5:3];
      assign rm_idx = modrm[2:0];
    end else if (IDX_W > 3) begin : g_idx_pad
      assign ro_idx = {{(IDX_W-3){1'b0}}, modrm[5:3]};
      assign rm_idx = {{(IDX_W-3){1'b0}}, modrm[2:0]};
    end else begin : g_idx_trunc
      assign ro_idx = modrm[3 +: IDX_W];
      assign rm_idx = modrm[0 +: IDX_W];
    end
  endgenerate

  assign rm_is_reg  = (modrm[7:6] == 2'b11);
  assign dest_valid = wr_en && (!wr_rmsel || rm_is_reg);
  assign dest_idx   = wr_rmsel ? rm_idx : ro_idx;

`ifdef SB_WB_BYPASS_EN
  // A source whose only pending write retires this cycle can proceed.
  assign ro_byp = wb_v && (wb_reg == ro_idx) && (cnt_q[ro_idx] == CNT_ONE);
  assign rm_byp = wb_v && (wb_reg == rm_idx) && (cnt_q[rm_idx] == CNT_ONE);
`else
  assign ro_byp = 1'b0;
  assign rm_byp = 1'b0;
`endif

  // Stall decision and accepted issue / retire qualifiers.
  always_comb begin
    ro_busy   = (cnt_q[ro_idx] != '0) && !ro_byp;
    rm_busy   = (cnt_q[rm_idx] != '0) && !rm_byp;
    dest_full = dest_valid && (cnt_q[dest_idx] == CNT_MAX);
    reg_dep   = v && ((ro_needed && ro_busy) ||
                      (rm_needed && rm_is_reg && rm_busy) ||
                      dest_full);
    inc       = issue && v && !reg_dep && dest_valid;
    dec       = wb_v && (cnt_q[wb_reg] != '0);
    underflow = wb_v && (cnt_q[wb_reg] == '0);
  end

  // Next counter values; flush wins, a same-register inc/dec pair cancels.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc && (dest_idx == IDX_W'(i)) &&
                   !(dec && (wb_reg == IDX_W'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec && (wb_reg == IDX_W'(i)) &&
                   !(inc && (dest_idx == IDX_W'(i)))) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // Pending-write counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_err <= 1'b0;
    else if (underflow) sb_err <= 1'b1;
  end

  // Per-register busy flags straight from the counters.
  always_comb begin
    for (int i = 0; i < NREGS; i++) busy[i] = (cnt_q[i] != '0);
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: the stimulus pushes hand-computed
// expectations, a monitor pops one per falling edge and compares.
module tb_reg_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       v, ro_needed, rm_needed;
  logic [7:0] modrm;
  logic       issue, wr_en, wr_rmsel;
  logic       wb_v;
  logic [2:0] wb_reg;
  logic       flush;
  logic       reg_dep;
  logic [7:0] busy;
  logic       sb_err;

  typedef struct {
    string      name;
    logic       dep;
    logic [7:0] busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef SB_WB_BYPASS_EN
  localparam logic BYP_DEP = 1'b0;
`else
  localparam logic BYP_DEP = 1'b1;
`endif

  reg_scoreboard #(.NREGS(8), .IDX_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .v(v), .ro_needed(ro_needed),
    .rm_needed(rm_needed), .modrm(modrm), .issue(issue), .wr_en(wr_en),
    .wr_rmsel(wr_rmsel), .wb_v(wb_v), .wb_reg(wb_reg), .flush(flush),
    .reg_dep(reg_dep), .busy(busy), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation is consumed per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      n_checks++;
      if (reg_dep !== cur.dep) begin
        n_errors++;
        $display("FAIL %s reg_dep: got %0b expected %0b", cur.name, reg_dep, cur.dep);
      end
      n_checks++;
      if (busy !== cur.busy) begin
        n_errors++;
        $display("FAIL %s busy: got %h expected %h", cur.name, busy, cur.busy);
      end
      n_checks++;
      if (sb_err !== cur.err) begin
        n_errors++;
        $display("FAIL %s sb_err: got %0b expected %0b", cur.name, sb_err, cur.err);
      end
    end
  end

  task automatic idle();
    v = 0; ro_needed = 0; rm_needed = 0; modrm = 8'h00;
    issue = 0; wr_en = 0; wr_rmsel = 0; wb_v = 0; wb_reg = 3'd0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic dep,
                            input logic [7:0] b, input logic err);
    exp_t e;
    e.name = name; e.dep = dep; e.busy = b; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic writer(input logic [7:0] m);
    idle(); v = 1; issue = 1; wr_en = 1; modrm = m;
  endtask

  task automatic wb(input logic [2:0] r);
    idle(); wb_v = 1; wb_reg = r;
  endtask

  initial begin
    rst_n = 0;
    idle();
    expect_out("reset", 0, 8'h00, 0);
    tick();
    tick();
    rst_n = 1;

    // Writer to reg 3, then dependent read, then writeback clears it.
    writer(8'hD8);                 expect_out("a_issue", 0, 8'h00, 0); tick();
    idle(); v = 1; ro_needed = 1; modrm = 8'hD8;
                                   expect_out("a_dep",   1, 8'h08, 0); tick();
    wb_v = 1; wb_reg = 3'd3;       expect_out("a_wb",    BYP_DEP, 8'h08, 0); tick();
    wb_v = 0;                      expect_out("a_clear", 0, 8'h00, 0); tick();

    // Saturate reg 5, structural stall, one retire lets the fourth in.
    writer(8'hE8);                 expect_out("b_w1",    0, 8'h00, 0); tick();
    writer(8'hE8);                 expect_out("b_w2",    0, 8'h20, 0); tick();
    writer(8'hE8);                 expect_out("b_w3",    0, 8'h20, 0); tick();
    writer(8'hE8);                 expect_out("b_full",  1, 8'h20, 0); tick();
    wb(3'd5);                      expect_out("b_wb",    0, 8'h20, 0); tick();
    writer(8'hE8);                 expect_out("b_w4",    0, 8'h20, 0); tick();
    idle(); v = 1; wr_en = 1; modrm = 8'hE8;
                                   expect_out("b_refull", 1, 8'h20, 0); tick();

    // Same-cycle issue and retire on reg 2 leaves count at 1.
    writer(8'hD0);                 expect_out("c_w1",    0, 8'h20, 0); tick();
    writer(8'hD0); wb_v = 1; wb_reg = 3'd2;
                                   expect_out("c_same",  0, 8'h24, 0); tick();
    idle();                        expect_out("c_hold",  0, 8'h24, 0); tick();
    wb(3'd2);                      expect_out("c_wb",    0, 8'h24, 0); tick();
    idle();                        expect_out("c_empty", 0, 8'h20, 0); tick();

    // Underflow on reg 6 sets the sticky error.
    wb(3'd6);                      expect_out("d_wb",    0, 8'h20, 0); tick();
    idle();                        expect_out("d_err",   0, 8'h20, 1); tick();

    // Flush beats a same-cycle issue; error survives flush.
    writer(8'hC8); flush = 1;      expect_out("e_flush", 0, 8'h20, 1); tick();
    idle();                        expect_out("e_clear", 0, 8'h00, 1); tick();
    writer(8'hD8);                 expect_out("e_w",     0, 8'h00, 1); tick();
    idle();                        expect_out("e_busy",  0, 8'h08, 1); tick();
    rst_n = 0;                     expect_out("e_async", 0, 8'h00, 0); tick();
    rst_n = 1; idle();             expect_out("e_post",  0, 8'h00, 0); tick();

    // r/m source only counts when mod == 11.
    writer(8'hF0);                 expect_out("f_w6",    0, 8'h00, 0); tick();
    idle(); v = 1; rm_needed = 1; modrm = 8'h06;
                                   expect_out("f_mem",   0, 8'h40, 0); tick();
    idle(); v = 1; rm_needed = 1; modrm = 8'hC6;
                                   expect_out("f_regrm", 1, 8'h40, 0); tick();
    writer(8'hC8);                 expect_out("f_w1",    0, 8'h40, 0); tick();
    idle(); v = 1; ro_needed = 1; modrm = 8'hC8; wb_v = 1; wb_reg = 3'd1;
                                   expect_out("f_byp",   BYP_DEP, 8'h42, 0); tick();
    idle();                        expect_out("f_after", 0, 8'h40, 0); tick();

    // r/m destination: memory form writes nothing, register form writes reg 7.
    writer(8'h07); wr_rmsel = 1;   expect_out("g_mem",   0, 8'h40, 0); tick();
    idle();                        expect_out("g_none",  0, 8'h40, 0); tick();
    writer(8'hC7); wr_rmsel = 1;   expect_out("g_reg",   0, 8'h40, 0); tick();
    idle();                        expect_out("g_dest7", 0, 8'hC0, 0); tick();

    tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 8, number of tracked architectural GPRs (power of 2, 2..16).
REQ-002 SHALL have parameter IDX_W, default 3, register index width (= log2 NREGS).
REQ-003 SHALL have parameter CNT_W, default 2, per-register pending-write counter width; max pending = 2^CNT_W-1.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports v, ro_needed, rm_needed  input  1 each  decode-stage valid, reg-field source used, r/m-field source used.
REQ-007 SHALL have port modrm  input  8  decode-stage ModR/M byte (mod[7:6], reg[5:3], rm[2:0]).
REQ-008 SHALL have ports issue, wr_en, wr_rmsel  input  1 each  decode instruction leaves decode, it writes a GPR, destination field select (0 = reg, 1 = r/m).
REQ-009 SHALL have ports wb_v  input  1  and wb_reg  input  IDX_W  writeback-stage retire of one GPR write.
REQ-010 SHALL have port flush  input  1  pipeline flush, discards all in-flight writers.
REQ-011 SHALL have ports reg_dep  output  1  stall request; busy  output  NREGS  per-register pending flag; sb_err  output  1  sticky underflow error.

Function
REQ-012 SHALL treat the r/m field as a register operand only when mod == 2'b11.
REQ-013 SHALL assert reg_dep combinationally (zero latency) when v=1 and (ro_needed=1 and cnt[reg]!=0, or rm_needed=1 and r/m is a register and cnt[rm]!=0).
REQ-014 SHALL also assert reg_dep when v=1, wr_en=1, destination is a register and cnt[dest]==max (structural stall; counters never overflow).
REQ-015 SHALL define destination as modrm[5:3] when wr_rmsel=0; modrm[2:0] when wr_rmsel=1 and mod==2'b11; no register destination otherwise.
REQ-016 SHALL accept an issue only when issue & v & !reg_dep; issue while reg_dep=1 SHALL be ignored.
REQ-017 SHALL increment cnt[dest] on the clock edge after an accepted issue with wr_en=1 and a register destination.
REQ-018 SHALL decrement cnt[wb_reg] on the clock edge when wb_v=1 and cnt[wb_reg]!=0.
REQ-019 SHALL leave cnt unchanged when increment and decrement target the same register in the same cycle.
REQ-020 SHALL, on wb_v=1 with cnt[wb_reg]==0, leave cnt at 0 and set sb_err=1, held until reset.
REQ-021 SHALL, on flush=1, clear all counters on the next edge; flush takes priority over same-cycle issue and writeback; sb_err unaffected.
REQ-022 SHALL drive busy[i] = (cnt[i] != 0), from registered state.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force all counters to 0, busy=0, sb_err=0; reg_dep then follows REQ-013/014 with empty counters (0).
REQ-024 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-operation discards all pending state.

Configuration
REQ-025 SHALL support macro SB_WB_BYPASS_EN: when defined, a source whose register equals wb_reg with wb_v=1 and cnt==1 in the same cycle SHALL NOT cause reg_dep (same-cycle writeback bypass); when undefined, reg_dep uses counters only and such a case stalls one extra cycle.

Verification
REQ-026 SHALL cover: issue writer to reg 3 (modrm=8'hD8, wr_rmsel=0); next cycle v=1, ro_needed=1, modrm reg=3 -> reg_dep=1, busy=8'h08; wb_v=1, wb_reg=3 -> reg_dep=0 following cycle.
REQ-027 SHALL cover: three accepted writers to reg 5 -> cnt=3, fourth writer to reg 5 -> reg_dep=1 and issue ignored; one writeback -> fourth accepted.
REQ-028 SHALL cover: same-cycle issue to reg 2 and wb_v=1 wb_reg=2 with cnt=1 -> cnt stays 1, busy[2]=1.
REQ-029 SHALL cover: wb_v=1 wb_reg=6 with cnt[6]=0 -> sb_err=1, remains 1 through flush, clears only on rst_n=0.
REQ-030 SHALL cover: counters non-zero, flush=1 with simultaneous issue -> busy=0 next cycle; rst_n pulsed low mid-stream -> busy=0 immediately without clock.
REQ-031 SHALL cover: rm_needed=1, modrm=8'h06 (mod=00) with cnt[6]!=0 -> reg_dep=0; with SB_WB_BYPASS_EN defined, cnt[1]=1, wb_reg=1, source reg 1 -> reg_dep=0 (undefined: reg_dep=1).
